// File: rtl/regs_wb.sv
// Writeback sequencer: merges ALU and load results into an in-order FIFO and
// drains one entry per cycle onto the register file write port, with forwarding.
module regs_wb #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [4:0]   alu_rd,
    input  logic [W-1:0] alu_val,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [4:0]   ld_rd,
    input  logic [W-1:0] ld_val,
    output logic         wen,
    output logic [4:0]   rd,
    output logic [W-1:0] rd_val,
    input  logic [4:0]   q_rs1,
    input  logic [4:0]   q_rs2,
    output logic         fwd1_hit,
    output logic [W-1:0] fwd1_val,
    output logic         fwd2_hit,
    output logic [W-1:0] fwd2_val,
    output logic         pending,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    ent_rd  [DEPTH];
    logic [W-1:0]  ent_val [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          ld_push;
    logic          alu_push;
    logic          pop;

    // Readiness only looks at the registered count; the load unit owns the last slot.
    assign free      = CW'(DEPTH) - count;
    assign ld_ready  = free >= CW'(1);
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !ld_valid);

    assign ld_push  = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign pop      = count != '0;
    assign alu_slot = ld_push ? wr_ptr + AW'(1) : wr_ptr;

    always_ff @(posedge clk) begin
        if (ld_push) begin
            ent_rd[wr_ptr]  <= ld_rd;
            ent_val[wr_ptr] <= ld_val;
        end
        if (alu_push) begin
            ent_rd[alu_slot]  <= alu_rd;
            ent_val[alu_slot] <= alu_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            wen    <= 1'b0;
            rd     <= 5'd0;
            rd_val <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(ld_push) + AW'(alu_push);
            count  <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
            if (pop) begin
                wen    <= 1'b1;
                rd     <= ent_rd[rd_ptr];
                rd_val <= ent_val[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end else begin
                wen <= 1'b0;
            end
        end
    end

    // Later matches overwrite earlier ones, so the newest pending write wins.
    function automatic logic [W:0] lookup(input logic [4:0] q);
        logic [W:0]    res;
        logic [AW-1:0] idx;
        res = '0;
        if (wen && (rd == q)) res = {1'b1, rd_val};
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((CW'(i) < count) && (ent_rd[idx] == q)) res = {1'b1, ent_val[idx]};
        end
        if (q == 5'd0) res = '0;
        return res;
    endfunction

    always_comb begin
        {fwd1_hit, fwd1_val} = lookup(q_rs1);
        {fwd2_hit, fwd2_val} = lookup(q_rs2);
    end

    assign pending = (count != '0) || wen;
    assign empty   = !pending;

endmodule

// File: tb/tb_regs_wb.sv
// Bench for regs_wb: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_regs_wb;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rstn;
    logic         alu_valid;
    logic         alu_ready;
    logic [4:0]   alu_rd;
    logic [W-1:0] alu_val;
    logic         ld_valid;
    logic         ld_ready;
    logic [4:0]   ld_rd;
    logic [W-1:0] ld_val;
    logic         wen;
    logic [4:0]   rd;
    logic [W-1:0] rd_val;
    logic [4:0]   q_rs1;
    logic [4:0]   q_rs2;
    logic         fwd1_hit;
    logic [W-1:0] fwd1_val;
    logic         fwd2_hit;
    logic [W-1:0] fwd2_val;
    logic         pending;
    logic         empty;

    regs_wb #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_val(alu_val),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_val(ld_val),
        .wen(wen), .rd(rd), .rd_val(rd_val),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .fwd1_hit(fwd1_hit), .fwd1_val(fwd1_val),
        .fwd2_hit(fwd2_hit), .fwd2_val(fwd2_val),
        .pending(pending), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]   rd;
        logic [W-1:0] val;
    } ent_t;

    ent_t         mq[$];
    logic         m_wen;
    logic [4:0]   m_rd;
    logic [W-1:0] m_val;
    bit           checking;
    int           n_checks;
    int           n_fail;
    logic [W:0]   exp_f1;
    logic [W:0]   exp_f2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_ld_ready();
        return (DEPTH - mq.size()) >= 1;
    endfunction

    function automatic bit m_alu_ready();
        int fr;
        fr = DEPTH - mq.size();
        return (fr >= 2) || (fr == 1 && !ld_valid);
    endfunction

    // Newest pending write wins: queue tail first, then the write port.
    function automatic logic [W:0] m_fwd(input logic [4:0] q);
        if (q == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == q) return {1'b1, mq[i].val};
        if (m_wen && m_rd == q) return {1'b1, m_val};
        return '0;
    endfunction

    task automatic model_update();
        bit   la;
        bit   aa;
        ent_t e;
        if (!rstn) begin
            mq.delete();
            m_wen = 1'b0;
            m_rd  = 5'd0;
            m_val = '0;
        end else begin
            la = ld_valid && m_ld_ready();
            aa = alu_valid && m_alu_ready();
            if (mq.size() > 0) begin
                e     = mq.pop_front();
                m_wen = 1'b1;
                m_rd  = e.rd;
                m_val = e.val;
            end else begin
                m_wen = 1'b0;
            end
            if (la && ld_rd != 5'd0) mq.push_back('{rd: ld_rd, val: ld_val});
            if (aa && alu_rd != 5'd0) mq.push_back('{rd: alu_rd, val: alu_val});
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            exp_f1 = m_fwd(q_rs1);
            exp_f2 = m_fwd(q_rs2);
            check("wen", 64'(wen), 64'(m_wen));
            check("rd", 64'(rd), 64'(m_rd));
            check("rd_val", 64'(rd_val), 64'(m_val));
            check("ld_ready", 64'(ld_ready), 64'(m_ld_ready()));
            check("alu_ready", 64'(alu_ready), 64'(m_alu_ready()));
            check("fwd1", 64'({fwd1_hit, fwd1_val}), 64'(exp_f1));
            check("fwd2", 64'({fwd2_hit, fwd2_val}), 64'(exp_f2));
            check("pending", 64'(pending), 64'(mq.size() != 0 || m_wen));
            check("empty", 64'(empty), 64'(!(mq.size() != 0 || m_wen)));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_stimulus(input logic av, input logic [4:0] ar, input logic [W-1:0] aval,
                                  input logic lv, input logic [4:0] lr, input logic [W-1:0] lval,
                                  input logic [4:0] q1, input logic [4:0] q2);
        alu_valid = av; alu_rd = ar; alu_val = aval;
        ld_valid  = lv; ld_rd  = lr; ld_val  = lval;
        q_rs1 = q1; q_rs2 = q2;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        checking = 1'b0;
        m_wen = 1'b0; m_rd = 5'd0; m_val = '0;
        rstn = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checking = 1'b1;
        check_output("reset_wen", 64'(wen), 64'd0);
        check_output("reset_empty", 64'(empty), 64'd1);
        check_output("reset_rd_val", 64'(rd_val), 64'd0);

        // Single ALU write shows up two edges later.
        rstn = 1'b1;
        apply_stimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("t1_wen", 64'(wen), 64'd1);
        check_output("t1_rd", 64'(rd), 64'd5);
        check_output("t1_val", 64'(rd_val), 64'hDEADBEEF);
        tick();
        check_output("t1_wen_off", 64'(wen), 64'd0);
        check_output("t1_empty", 64'(empty), 64'd1);

        // Load enqueues before ALU in the same cycle.
        apply_stimulus(1, 3, 32'h22, 1, 3, 32'h11, 3, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 3, 0);
        tick();
        check_output("t2_first", 64'({wen, rd, rd_val}), 64'({1'b1, 5'd3, 32'h11}));
        check_output("t2_fwd_mid", 64'({fwd1_hit, fwd1_val}), 64'({1'b1, 32'h22}));
        tick();
        check_output("t2_second", 64'({wen, rd, rd_val}), 64'({1'b1, 5'd3, 32'h22}));
        tick();
        check_output("t2_done", 64'({wen, fwd1_hit}), 64'd0);

        // x0 handshake completes without allocating anything.
        apply_stimulus(1, 0, 32'h55, 0, 0, 0, 0, 0);
        #1;
        check_output("t4_ready", 64'(alu_ready), 64'd1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t4_pending", 64'(pending), 64'd0);
        check_output("t4_fwd", 64'(fwd1_hit), 64'd0);
        tick();
        check_output("t4_wen", 64'(wen), 64'd0);

        // Forwarding from the write port stage.
        apply_stimulus(1, 7, 32'h99, 0, 0, 0, 7, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 7, 0);
        tick();
        check_output("t5_port_fwd", 64'({wen, fwd1_hit, fwd1_val}), 64'({1'b1, 1'b1, 32'h99}));
        tick();
        check_output("t5_gone", 64'(fwd1_hit), 64'd0);

        // Build up to three queued entries, then exercise the last-slot priority.
        apply_stimulus(1, 2, 32'hA2, 1, 1, 32'hA1, 0, 0);
        tick();
        apply_stimulus(1, 4, 32'hA4, 1, 3, 32'hA3, 0, 0);
        tick();
        apply_stimulus(1, 6, 32'hA6, 1, 5, 32'hA5, 0, 0);
        #1;
        check_output("t3_alu_blocked", 64'({alu_ready, ld_ready}), 64'({1'b0, 1'b1}));
        ld_valid = 1'b0;
        #1;
        check_output("t3_alu_last", 64'(alu_ready), 64'd1);
        tick();
        check_output("t3_wen", 64'({wen, rd}), 64'({1'b1, 5'd2}));

        // Reset with entries queued and the write port active.
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        tick();
        check_output("t6_wen", 64'(wen), 64'd0);
        check_output("t6_pending", 64'(pending), 64'd0);
        rstn = 1'b1;
        tick();
        tick();
        check_output("t6_quiet", 64'({wen, empty}), 64'({1'b0, 1'b1}));

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rstn = ($urandom_range(0, 63) != 0);
            apply_stimulus($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                           $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end
        rstn = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < DEPTH + 3; c++) tick();
        check_output("final_empty", 64'(empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
